// File: rtl/route_comp_pipe_pkg.sv
// route_comp_pipe shared constants: port order and direction codes.
// Optional torus build is selected by ROUTE_COMP_TORUS_EN.
package route_comp_pipe_pkg;

    localparam int P_W = 0;
    localparam int P_E = 1;
    localparam int P_S = 2;
    localparam int P_N = 3;
    localparam int P_L = 4;

    localparam int NUM_PORT_DEF = 5;

    localparam int DIR_W = 0;
    localparam int DIR_E = 1;
    localparam int DIR_S = 2;
    localparam int DIR_N = 3;
    localparam int DIR_L = 4;

endpackage

// File: rtl/route_comp_core.sv
// Combinational next-hop and productive-port computation.
// ROUTE_COMP_TORUS_EN selects wrap-around, torus-minimal routing.
module route_comp_core
    import route_comp_pipe_pkg::*;
#(
    parameter int SIZE_X      = 4,
    parameter int SIZE_Y      = 4,
    parameter int WIDTH_COORD = 2,
    parameter int NUM_PORT    = NUM_PORT_DEF,
    parameter int OUT_DIR     = DIR_L
) (
    input  logic [WIDTH_COORD-1:0] cur_x,
    input  logic [WIDTH_COORD-1:0] cur_y,
    input  logic [WIDTH_COORD-1:0] dst_x,
    input  logic [WIDTH_COORD-1:0] dst_y,
    output logic [NUM_PORT-1:0]    prod,
    output logic                   err
);

    localparam int CW = WIDTH_COORD + 1;
    localparam logic [CW-1:0] SX  = CW'(SIZE_X);
    localparam logic [CW-1:0] SY  = CW'(SIZE_Y);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] cx, cy, dx, dy, nx, ny;
    logic          edge_err;
    logic          range_err;
    // {plus, minus} per dimension
    logic [1:0]    dir_x, dir_y;

    assign cx = {1'b0, cur_x};
    assign cy = {1'b0, cur_y};
    assign dx = {1'b0, dst_x};
    assign dy = {1'b0, dst_y};

`ifdef ROUTE_COMP_TORUS_EN
    // Shortest way round the ring; a half-ring tie offers both ways.
    function automatic logic [1:0] torus_dir(
        input logic [CW-1:0] d,
        input logic [CW-1:0] n,
        input logic [CW-1:0] s
    );
        logic [CW-1:0] m;
        logic [CW:0]   m2;
        m  = (d >= n) ? d - n : d + s - n;
        m2 = {m, 1'b0};
        if (m == '0)
            return 2'b00;
        else if (m2 < {1'b0, s})
            return 2'b10;
        else if (m2 > {1'b0, s})
            return 2'b01;
        else
            return 2'b11;
    endfunction
`endif

    // Next-hop coordinate of the neighbour this instance feeds.
    always_comb begin
        nx       = cx;
        ny       = cy;
        edge_err = 1'b0;
        case (OUT_DIR)
            DIR_W: begin
`ifdef ROUTE_COMP_TORUS_EN
                nx = (cx == '0) ? SX - ONE : cx - ONE;
`else
                edge_err = (cx == '0);
                nx       = cx - ONE;
`endif
            end
            DIR_E: begin
`ifdef ROUTE_COMP_TORUS_EN
                nx = (cx == SX - ONE) ? '0 : cx + ONE;
`else
                edge_err = (cx == SX - ONE);
                nx       = cx + ONE;
`endif
            end
            DIR_S: begin
`ifdef ROUTE_COMP_TORUS_EN
                ny = (cy == '0) ? SY - ONE : cy - ONE;
`else
                edge_err = (cy == '0);
                ny       = cy - ONE;
`endif
            end
            DIR_N: begin
`ifdef ROUTE_COMP_TORUS_EN
                ny = (cy == SY - ONE) ? '0 : cy + ONE;
`else
                edge_err = (cy == SY - ONE);
                ny       = cy + ONE;
`endif
            end
            default: ;
        endcase
    end

    // Per-dimension direction relative to the next hop.
    always_comb begin
`ifdef ROUTE_COMP_TORUS_EN
        dir_x = torus_dir(dx, nx, SX);
        dir_y = torus_dir(dy, ny, SY);
`else
        dir_x = {dx > nx, dx < nx};
        dir_y = {dy > ny, dy < ny};
`endif
    end

    // Productive vector; any error forces an empty vector.
    always_comb begin
        range_err = (dx >= SX) || (dy >= SY);
        err       = range_err || edge_err;
        prod      = '0;
        if (!err) begin
            prod[P_W] = dir_x[0];
            prod[P_E] = dir_x[1];
            prod[P_S] = dir_y[0];
            prod[P_N] = dir_y[1];
            prod[P_L] = (dir_x == 2'b00) && (dir_y == 2'b00);
        end
    end

endmodule

// File: rtl/route_comp_pipe.sv
// Registered route-computation stage with a 2-entry output FIFO.
// ROUTE_COMP_TORUS_EN enables torus routing in route_comp_core.
module route_comp_pipe
    import route_comp_pipe_pkg::*;
#(
    parameter int SIZE_X      = 4,
    parameter int SIZE_Y      = 4,
    parameter int WIDTH_COORD = 2,
    parameter int NUM_PORT    = NUM_PORT_DEF,
    parameter int OUT_DIR     = DIR_W,
    parameter int TAG_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH_COORD-1:0] cur_x,
    input  logic [WIDTH_COORD-1:0] cur_y,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH_COORD-1:0] in_dst_x,
    input  logic [WIDTH_COORD-1:0] in_dst_y,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_PORT-1:0]    out_prod,
    output logic                   out_err,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int EW = NUM_PORT + 1 + TAG_W;

    logic [NUM_PORT-1:0] new_prod;
    logic                new_err;
    logic [EW-1:0]       entry;
    logic [EW-1:0]       head;
    logic [EW-1:0]       tail;
    logic [1:0]          cnt;
    logic [1:0]          cnt_next;
    logic                push;
    logic                pop;

    route_comp_core #(
        .SIZE_X      (SIZE_X),
        .SIZE_Y      (SIZE_Y),
        .WIDTH_COORD (WIDTH_COORD),
        .NUM_PORT    (NUM_PORT),
        .OUT_DIR     (OUT_DIR)
    ) u_core (
        .cur_x (cur_x),
        .cur_y (cur_y),
        .dst_x (in_dst_x),
        .dst_y (in_dst_y),
        .prod  (new_prod),
        .err   (new_err)
    );

    assign entry     = {new_prod, new_err, in_tag};
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (cnt != 2'd0);
    assign {out_prod, out_err, out_tag} = head;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        cnt_next = cnt;
        case ({push, pop})
            2'b10:   cnt_next = cnt + 2'd1;
            2'b01:   cnt_next = cnt - 2'd1;
            default: ;
        endcase
    end

    // Head/tail storage; head always drives the outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 2'd0;
            in_ready <= 1'b1;
            head     <= '0;
            tail     <= '0;
        end else begin
            cnt      <= cnt_next;
            in_ready <= (cnt_next < 2'd2);
            if (push && (cnt == 2'd0 || pop))
                head <= entry;
            else if (pop && cnt == 2'd2)
                head <= tail;
            if (push && !pop && cnt == 2'd1)
                tail <= entry;
        end
    end

endmodule

// File: tb/tb_route_comp_pipe.sv
// Directed bench for route_comp_pipe (mesh or ROUTE_COMP_TORUS_EN build).
// Two instances: A serves E with 2-bit coords, B serves W with 3-bit coords.
module tb_route_comp_pipe;

`ifdef ROUTE_COMP_TORUS_EN
    localparam logic [31:0] XA_03 = 32'b01110;
    localparam logic [31:0] XA_33 = 32'b01100;
    localparam logic [31:0] XA_11 = 32'b01010;
    localparam logic [31:0] EA_11 = 32'd0;
    localparam logic [31:0] XB_00 = 32'b00010;
    localparam logic [31:0] EB_00 = 32'd0;
    localparam logic [31:0] XB_10 = 32'b00011;
    localparam logic [31:0] XB_20 = 32'b00001;
    localparam logic [31:0] XB_30 = 32'b01111;
`else
    localparam logic [31:0] XA_03 = 32'b01001;
    localparam logic [31:0] XA_33 = 32'b01000;
    localparam logic [31:0] XA_11 = 32'd0;
    localparam logic [31:0] EA_11 = 32'd1;
    localparam logic [31:0] XB_00 = 32'd0;
    localparam logic [31:0] EB_00 = 32'd1;
    localparam logic [31:0] XB_10 = 32'd0;
    localparam logic [31:0] XB_20 = 32'd0;
    localparam logic [31:0] XB_30 = 32'b00110;
`endif

    logic       clk = 1'b0;
    logic       rst_n;

    logic [1:0] a_cx, a_cy, a_dx, a_dy;
    logic       a_valid, a_ready, a_ovalid, a_oready, a_err;
    logic [7:0] a_tag, a_otag;
    logic [4:0] a_prod;

    logic [2:0] b_cx, b_cy, b_dx, b_dy;
    logic       b_valid, b_ready, b_ovalid, b_oready, b_err;
    logic [7:0] b_tag, b_otag;
    logic [4:0] b_prod;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    route_comp_pipe #(
        .SIZE_X (4), .SIZE_Y (4), .WIDTH_COORD (2),
        .NUM_PORT (5), .OUT_DIR (1), .TAG_W (8)
    ) dut_a (
        .clk (clk), .rst_n (rst_n),
        .cur_x (a_cx), .cur_y (a_cy),
        .in_valid (a_valid), .in_ready (a_ready),
        .in_dst_x (a_dx), .in_dst_y (a_dy), .in_tag (a_tag),
        .out_valid (a_ovalid), .out_ready (a_oready),
        .out_prod (a_prod), .out_err (a_err), .out_tag (a_otag)
    );

    route_comp_pipe #(
        .SIZE_X (4), .SIZE_Y (4), .WIDTH_COORD (3),
        .NUM_PORT (5), .OUT_DIR (0), .TAG_W (8)
    ) dut_b (
        .clk (clk), .rst_n (rst_n),
        .cur_x (b_cx), .cur_y (b_cy),
        .in_valid (b_valid), .in_ready (b_ready),
        .in_dst_x (b_dx), .in_dst_y (b_dy), .in_tag (b_tag),
        .out_valid (b_ovalid), .out_ready (b_oready),
        .out_prod (b_prod), .out_err (b_err), .out_tag (b_otag)
    );

    task automatic chk(input string name,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    task automatic send_a(input logic [1:0] dx, input logic [1:0] dy,
                          input logic [7:0] tg);
        @(negedge clk);
        a_valid = 1'b1;
        a_dx    = dx;
        a_dy    = dy;
        a_tag   = tg;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [2:0] dx, input logic [2:0] dy,
                          input logic [7:0] tg);
        @(negedge clk);
        b_valid = 1'b1;
        b_dx    = dx;
        b_dy    = dy;
        b_tag   = tg;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        a_cx = 2'd2; a_cy = 2'd1; a_dx = '0; a_dy = '0;
        a_valid  = 1'b0; a_oready = 1'b1; a_tag = '0;
        b_cx = 3'd0; b_cy = 3'd0; b_dx = '0; b_dy = '0;
        b_valid  = 1'b0; b_oready = 1'b1; b_tag = '0;

        #12;
        chk("rst_valid", 32'(a_ovalid), 32'd0);
        chk("rst_ready", 32'(a_ready), 32'd1);
        chk("rst_prod", 32'(a_prod), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_tag", 32'(a_otag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // A: cur=(2,1), E -> next=(3,1)
        send_a(2'd3, 2'd1, 8'h5A);
        chk("a31_valid", 32'(a_ovalid), 32'd1);
        chk("a31_prod", 32'(a_prod), 32'b10000);
        chk("a31_err", 32'(a_err), 32'd0);
        chk("a31_tag", 32'(a_otag), 32'h5A);
        send_a(2'd0, 2'd3, 8'h11);
        chk("a03_prod", 32'(a_prod), XA_03);
        chk("a03_tag", 32'(a_otag), 32'h11);
        send_a(2'd3, 2'd0, 8'h12);
        chk("a30_prod", 32'(a_prod), 32'b00100);
        chk("a30_valid", 32'(a_ovalid), 32'd1);
        send_a(2'd3, 2'd3, 8'h13);
        chk("a33_prod", 32'(a_prod), XA_33);
        chk("a33_tag", 32'(a_otag), 32'h13);

        // A: cur=(3,0), E is the east edge in a mesh
        a_cx = 2'd3; a_cy = 2'd0;
        send_a(2'd1, 2'd1, 8'h14);
        chk("aedge_err", 32'(a_err), EA_11);
        chk("aedge_prod", 32'(a_prod), XA_11);
        @(posedge clk);
        #1;
        chk("a_drained", 32'(a_ovalid), 32'd0);

        // Backpressure: hold out_ready low, offer three requests
        a_cx = 2'd2; a_cy = 2'd1; a_oready = 1'b0;
        @(negedge clk);
        a_valid = 1'b1; a_dx = 2'd3; a_dy = 2'd1; a_tag = 8'h21;
        @(posedge clk);
        #1;
        a_tag = 8'h22;
        @(posedge clk);
        #1;
        a_tag = 8'h23;
        chk("bp_ready_full", 32'(a_ready), 32'd0);
        chk("bp_head1", 32'(a_otag), 32'h21);
        @(posedge clk);
        #1;
        chk("bp_ready_hold", 32'(a_ready), 32'd0);
        chk("bp_hold_tag", 32'(a_otag), 32'h21);
        chk("bp_hold_prod", 32'(a_prod), 32'b10000);
        chk("bp_hold_valid", 32'(a_ovalid), 32'd1);
        a_valid = 1'b0; a_oready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_pop1_tag", 32'(a_otag), 32'h22);
        chk("bp_pop1_ready", 32'(a_ready), 32'd1);
        chk("bp_pop1_valid", 32'(a_ovalid), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_empty", 32'(a_ovalid), 32'd0);

        // Reset with two entries buffered
        a_oready = 1'b0;
        @(negedge clk);
        a_valid = 1'b1; a_dx = 2'd0; a_dy = 2'd0; a_tag = 8'h31;
        @(posedge clk);
        #1;
        a_tag = 8'h32;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        chk("pre_rst_full", 32'(a_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(a_ovalid), 32'd0);
        chk("mid_rst_ready", 32'(a_ready), 32'd1);
        chk("mid_rst_prod", 32'(a_prod), 32'd0);
        chk("mid_rst_tag", 32'(a_otag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; a_oready = 1'b1;
        send_a(2'd3, 2'd3, 8'h77);
        chk("post_rst_valid", 32'(a_ovalid), 32'd1);
        chk("post_rst_tag", 32'(a_otag), 32'h77);
        chk("post_rst_prod", 32'(a_prod), XA_33);

        // B: cur=(0,0), W -> off-grid in a mesh, next=(3,0) in a torus
        send_b(3'd4, 3'd0, 8'h41);
        chk("b_range_err", 32'(b_err), 32'd1);
        chk("b_range_prod", 32'(b_prod), 32'd0);
        send_b(3'd0, 3'd0, 8'h42);
        chk("b00_prod", 32'(b_prod), XB_00);
        chk("b00_err", 32'(b_err), EB_00);
        send_b(3'd1, 3'd0, 8'h43);
        chk("b10_prod", 32'(b_prod), XB_10);
        send_b(3'd2, 3'd0, 8'h44);
        chk("b20_prod", 32'(b_prod), XB_20);
        chk("b20_tag", 32'(b_otag), 32'h44);

        // B: cur=(2,2), W -> next=(1,2)
        b_cx = 3'd2; b_cy = 3'd2;
        send_b(3'd1, 3'd2, 8'h45);
        chk("b12_prod", 32'(b_prod), 32'b10000);
        chk("b12_err", 32'(b_err), 32'd0);
        send_b(3'd3, 3'd0, 8'h46);
        chk("b30_prod", 32'(b_prod), XB_30);
        chk("b30_valid", 32'(b_ovalid), 32'd1);
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
